string_buffer: RTL
==================

Name: string_buffer

Overview:
Consumer end of the extended-ASCII key stream: accepts one-cycle asciiex command strobes and keeps a ROWS x COLS character buffer with an edit cursor. Printable codes are written at the cursor. Backspace and arrow codes move the cursor and edit the buffer. A registered read port lets a display scanner fetch cells. A one-cycle update strobe reports every cell write so the display can refresh only that cell.

Parameters:
COLS, 16, characters per row
ROWS, 2, number of rows
COL_BITS, 4, width of column index; 2**COL_BITS >= COLS
ROW_BITS, 1, width of row index; 2**ROW_BITS >= ROWS

Ports:
clk  input  1  system clock, all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_sclr  input  1  synchronous clear, same effect as reset
i_en  input  1  command enable; when low, i_asciiex_en is ignored
i_asciiex  input  8  command/character code
i_asciiex_en  input  1  one-cycle strobe, i_asciiex valid
i_rd_row  input  ROW_BITS  read row
i_rd_col  input  COL_BITS  read column
o_rd_dat  output  8  cell at (i_rd_row,i_rd_col), registered
o_cur_row  output  ROW_BITS  cursor row
o_cur_col  output  COL_BITS  cursor column
o_upd  output  1  one-cycle pulse, a cell was written
o_upd_row  output  ROW_BITS  written cell row
o_upd_col  output  COL_BITS  written cell column
o_upd_dat  output  8  written value
o_err  output  1  one-cycle pulse, unsupported code received

Behaviour:
- Clocking:
  - Single clock domain.
  - i_rst_n low asynchronously sets: all cells 8'h20, cursor (0,0), o_rd_dat 8'h20, o_upd/o_err 0, o_upd_row/col/dat 0.
  - i_sclr high at a clock edge has the same effect synchronously.
  - i_sclr overrides any command in the same cycle.
- Command acceptance:
  - A command is accepted when i_en & i_asciiex_en at a clock edge.
  - Every accepted command is processed in that single cycle; there is no backpressure and no busy state.
  - Back-to-back strobes on consecutive cycles must all be applied in order.
- Command decode (cursor (r,c) before the edge):
  - 8'h20..8'h7E printable:
    - cell(r,c) <= code.
    - Advance the cursor. If c < COLS-1, c+1. Else c=0 and r+1; r wraps from ROWS-1 to 0.
  - 8'h08 backspace:
    - At (0,0): no-op, no o_upd.
    - Otherwise the cursor retreats one position: c-1, or c=COLS-1 with r-1 when c==0.
    - The new cursor cell is written 8'h20.
  - 8'h02 right: c+1, saturating at COLS-1. Row unchanged, no write.
  - 8'h04 left: c-1, saturating at 0. Row unchanged, no write.
  - 8'h03 down: c=0 and r+1, wrapping ROWS-1 -> 0. No write.
  - Any other code: state unchanged, o_err=1 for exactly the next cycle.
- Outputs:
  - o_cur_row/o_cur_col are registers and reflect the new cursor one edge after acceptance.
  - o_upd is registered. It is high for one cycle after an edge that wrote a cell, carrying that cell's row/col/value.
  - o_upd_row/col/dat hold their last value while o_upd is low.
- Read port:
  - o_rd_dat is updated every edge from the addressed cell, giving 1-cycle latency.
  - A read of the cell written on the same edge returns the old value; the new value appears on the following edge.
  - Out-of-range read address (row >= ROWS or col >= COLS) returns 8'h20.
- Mid-operation and width rules:
  - Reset or i_sclr asserted mid-stream discards the command presented that cycle.
  - Cursor indices never take values >= ROWS / COLS.
  - All index arithmetic is done at ROW_BITS/COL_BITS width with explicit wrap/saturate compares, never natural overflow.

Test Plan:
- Reset, then read all cells -> every o_rd_dat = 8'h20; cursor (0,0); o_upd=0, o_err=0.
- Send 8'h41 three times on consecutive cycles -> cells (0,0..2)=8'h41; cursor (0,3); three o_upd pulses with cols 0,1,2.
- Cursor at (0,15), send 8'h41 -> cell (0,15)=8'h41, cursor (1,0). Cursor at (1,15), send 8'h41 -> cursor wraps to (0,0).
- Cursor at (1,0), send 8'h08 -> cursor (0,15), cell (0,15)=8'h20, o_upd row 0 col 15. At (0,0), 8'h08 -> no change, no o_upd.
- Arrows from (0,0): 8'h04 -> stays (0,0); 8'h02 x20 -> (0,15); 8'h03 -> (1,0); 8'h03 -> (0,0). No o_upd for any of them.
- 8'h7F strobe -> o_err one cycle, state unchanged. Strobe with i_en=0 -> ignored. 8'h41 with i_sclr=1 -> buffer cleared, cursor (0,0), no o_upd.

Source files
------------

// File: rtl/string_buffer.sv
// string_buffer: ROWS x COLS character buffer with an edit cursor, driven by one-cycle asciiex command strobes
module string_buffer #(
    parameter int COLS     = 16,
    parameter int ROWS     = 2,
    parameter int COL_BITS = 4,
    parameter int ROW_BITS = 1
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic                i_sclr,
    input  logic                i_en,
    input  logic [7:0]          i_asciiex,
    input  logic                i_asciiex_en,
    input  logic [ROW_BITS-1:0] i_rd_row,
    input  logic [COL_BITS-1:0] i_rd_col,
    output logic [7:0]          o_rd_dat,
    output logic [ROW_BITS-1:0] o_cur_row,
    output logic [COL_BITS-1:0] o_cur_col,
    output logic                o_upd,
    output logic [ROW_BITS-1:0] o_upd_row,
    output logic [COL_BITS-1:0] o_upd_col,
    output logic [7:0]          o_upd_dat,
    output logic                o_err
);
    localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'(ROWS - 1);
    localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS:0]   ROW_LIM = (ROW_BITS + 1)'(ROWS);
    localparam logic [COL_BITS:0]   COL_LIM = (COL_BITS + 1)'(COLS);

    logic [7:0]          mem_q [ROWS][COLS];
    logic [ROW_BITS-1:0] cur_row_q, cur_row_d, row_inc, row_dec, wr_row, upd_row_q, upd_row_d;
    logic [COL_BITS-1:0] cur_col_q, cur_col_d, wr_col, upd_col_q, upd_col_d;
    logic [7:0]          wr_dat, upd_dat_q, upd_dat_d, rd_dat_q, rd_dat_d;
    logic                we, upd_q, upd_d, err_q, err_d;

    always_comb begin
        cur_row_d = cur_row_q;
        cur_col_d = cur_col_q;
        we        = 1'b0;
        wr_row    = cur_row_q;
        wr_col    = cur_col_q;
        wr_dat    = i_asciiex;
        err_d     = 1'b0;
        row_inc   = (cur_row_q == ROW_MAX) ? '0 : cur_row_q + ROW_BITS'(1);
        row_dec   = (cur_row_q == '0) ? ROW_MAX : cur_row_q - ROW_BITS'(1);
        if (i_en && i_asciiex_en) begin
            case (i_asciiex) inside
                [8'h20:8'h7E]: begin
                    we        = 1'b1;
                    cur_col_d = (cur_col_q == COL_MAX) ? '0 : cur_col_q + COL_BITS'(1);
                    cur_row_d = (cur_col_q == COL_MAX) ? row_inc : cur_row_q;
                end
                8'h08: begin
                    if (cur_row_q != '0 || cur_col_q != '0) begin
                        we        = 1'b1;
                        cur_col_d = (cur_col_q == '0) ? COL_MAX : cur_col_q - COL_BITS'(1);
                        cur_row_d = (cur_col_q == '0) ? row_dec : cur_row_q;
                        wr_row    = cur_row_d;
                        wr_col    = cur_col_d;
                        wr_dat    = 8'h20;
                    end
                end
                8'h02: cur_col_d = (cur_col_q == COL_MAX) ? COL_MAX : cur_col_q + COL_BITS'(1);
                8'h04: cur_col_d = (cur_col_q == '0) ? '0 : cur_col_q - COL_BITS'(1);
                8'h03: begin
                    cur_col_d = '0;
                    cur_row_d = row_inc;
                end
                default: err_d = 1'b1;
            endcase
        end
        upd_d     = we;
        upd_row_d = we ? wr_row : upd_row_q;
        upd_col_d = we ? wr_col : upd_col_q;
        upd_dat_d = we ? wr_dat : upd_dat_q;
        rd_dat_d  = ({1'b0, i_rd_row} < ROW_LIM && {1'b0, i_rd_col} < COL_LIM)
                  ? mem_q[i_rd_row][i_rd_col] : 8'h20;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_q     <= '{default: 8'h20};
            cur_row_q <= '0;
            cur_col_q <= '0;
            rd_dat_q  <= 8'h20;
            upd_q     <= 1'b0;
            upd_row_q <= '0;
            upd_col_q <= '0;
            upd_dat_q <= '0;
            err_q     <= 1'b0;
        end else if (i_sclr) begin
            mem_q     <= '{default: 8'h20};
            cur_row_q <= '0;
            cur_col_q <= '0;
            rd_dat_q  <= 8'h20;
            upd_q     <= 1'b0;
            upd_row_q <= '0;
            upd_col_q <= '0;
            upd_dat_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (we) mem_q[wr_row][wr_col] <= wr_dat;
            cur_row_q <= cur_row_d;
            cur_col_q <= cur_col_d;
            rd_dat_q  <= rd_dat_d;
            upd_q     <= upd_d;
            upd_row_q <= upd_row_d;
            upd_col_q <= upd_col_d;
            upd_dat_q <= upd_dat_d;
            err_q     <= err_d;
        end
    end

    assign o_rd_dat  = rd_dat_q;
    assign o_cur_row = cur_row_q;
    assign o_cur_col = cur_col_q;
    assign o_upd     = upd_q;
    assign o_upd_row = upd_row_q;
    assign o_upd_col = upd_col_q;
    assign o_upd_dat = upd_dat_q;
    assign o_err     = err_q;
endmodule
